pipelined_ripple_adder: RTL and testbench

//  Parametrised successor to the 4-bit ripple-carry adder: WIDTH-bit add/subtract, carry chain split into

---
 rtl/pipelined_ripple_adder_pkg.sv | 5 +
 rtl/ripple_chunk_adder.sv | 24 ++
 rtl/pipelined_ripple_adder.sv | 116 +++++++++++
 tb/tb_pipelined_ripple_adder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_ripple_adder_pkg.sv
// pipelined_ripple_adder_pkg: default geometry shared by the pipelined adder and its users
package pipelined_ripple_adder_pkg;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;
endpackage

// File: rtl/ripple_chunk_adder.sv
// ripple_chunk_adder: combinational CHUNK-bit ripple-carry adder with carry into the top bit
module ripple_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] c;
  always_comb begin
    c = '0;
    c[0] = cin;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit add/sub, carry chain split over STAGES registered ripple chunks
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int CHUNK = WIDTH / STAGES;
  if (WIDTH % STAGES != 0) begin : g_bad
    $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES");
  end
  logic [STAGES-1:0] v, rdy;
  logic [WIDTH-1:0] b_eff;
  logic nr;
  assign b_eff = sub ? ~b : b;
  // Ready ripples back from the consumer: a stage can load if empty or if its successor can take it.
  always_comb begin
    nr = out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v[k] || nr;
      nr = rdy[k];
    end
  end
  assign in_ready = rdy[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;
    logic [CHUNK-1:0] ca, cb, cs;
    logic ci, co, sv, sz, rv, rc, rz;
    logic [HI-1:0] ns, rs;
    if (k == 0) begin : g_src
      assign ca = a[CHUNK-1:0];
      assign cb = b_eff[CHUNK-1:0];
      assign ci = sub | cin;
      assign sv = in_valid;
      assign sz = 1'b1;
      assign ns = cs;
    end else begin : g_src
      assign ca = g_stage[k-1].g_fwd.ra[HI-1:LO];
      assign cb = g_stage[k-1].g_fwd.rb[HI-1:LO];
      assign ci = g_stage[k-1].rc;
      assign sv = g_stage[k-1].rv;
      assign sz = g_stage[k-1].rz;
      assign ns = {cs, g_stage[k-1].rs};
    end
    // Operand bits above this chunk ride along until their own stage consumes them.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] ua, ub, ra, rb;
      logic msb_unused;
      if (k == 0) begin : g_in
        assign ua = a[WIDTH-1:HI];
        assign ub = b_eff[WIDTH-1:HI];
      end else begin : g_in
        assign ua = g_stage[k-1].g_fwd.ra[WIDTH-1:HI];
        assign ub = g_stage[k-1].g_fwd.rb[WIDTH-1:HI];
      end
      ripple_chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a(ca), .b(cb), .cin(ci), .sum(cs), .cout(co), .c_msb(msb_unused)
      );
      always_ff @(posedge clk)
        if (rst) begin
          ra <= '0;
          rb <= '0;
        end else if (rdy[k] && sv) begin
          ra <= ua;
          rb <= ub;
        end
    end else begin : g_last
      logic cm, rm;
      ripple_chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a(ca), .b(cb), .cin(ci), .sum(cs), .cout(co), .c_msb(cm)
      );
      always_ff @(posedge clk)
        if (rst) rm <= 1'b0;
        else if (rdy[k] && sv) rm <= cm;
    end
    always_ff @(posedge clk)
      if (rst) begin
        rv <= 1'b0;
        rc <= 1'b0;
        rz <= 1'b0;
        rs <= '0;
      end else begin
        if (flush) rv <= 1'b0;
        else if (rdy[k]) rv <= sv;
        if (rdy[k] && sv) begin
          rs <= ns;
          rc <= co;
          rz <= sz & ~|cs;
        end
      end
    assign v[k] = rv;
  end
  assign out_valid = v[STAGES-1];
  assign sum  = g_stage[STAGES-1].rs;
  assign cout = g_stage[STAGES-1].rc;
  assign zero = g_stage[STAGES-1].rz;
  assign ovf  = g_stage[STAGES-1].g_last.rm ^ g_stage[STAGES-1].rc;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: directed checks of the 16-bit, 4-stage pipelined adder
module tb_pipelined_ripple_adder;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );
  task automatic run_one(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                         output logic [18:0] res, output int lat);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = {sum, cout, ovf, zero};
  endtask
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({out_valid, sum, cout, ovf, zero} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 00000", {out_valid, sum, cout, ovf, zero});
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst = 1'b0;
  endtask
  task automatic test_add();
    logic [15:0] ta [4] = '{16'h0005, 16'hFFFF, 16'h7FFF, 16'h0000};
    logic [15:0] tb [4] = '{16'h0003, 16'hFFFF, 16'h0001, 16'h0000};
    logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [18:0] ex [4] = '{{16'h0008, 3'b000}, {16'hFFFF, 3'b100}, {16'h8000, 3'b010}, {16'h0000, 3'b001}};
    logic [18:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_one(ta[i], tb[i], tc[i], 1'b0, res, lat);
      n_chk++;
      if (lat != 4) begin
        n_fail++;
        $display("FAIL add%0d_latency: got %0d expected 4", i, lat);
      end
      n_chk++;
      if (res !== ex[i]) begin
        n_fail++;
        $display("FAIL add%0d_result {sum,cout,ovf,zero}: got %h expected %h", i, res, ex[i]);
      end
    end
  endtask
  task automatic test_sub();
    logic [15:0] ta [3] = '{16'h0005, 16'h0003, 16'h8000};
    logic [15:0] tb [3] = '{16'h0005, 16'h0005, 16'h0001};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [18:0] ex [3] = '{{16'h0000, 3'b101}, {16'hFFFE, 3'b000}, {16'h7FFF, 3'b110}};
    logic [18:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(ta[i], tb[i], tc[i], 1'b1, res, lat);
      n_chk++;
      if (res !== ex[i] || lat != 4) begin
        n_fail++;
        $display("FAIL sub%0d_result {sum,cout,ovf,zero}: got %h lat %0d expected %h lat 4", i, res, lat, ex[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] ta [8] = '{16'h0000, 16'h0123, 16'h0246, 16'h0369, 16'h048C, 16'h05AF, 16'h06D2, 16'h07F5};
    logic [15:0] ex [8] = '{16'h1000, 16'h1123, 16'h1246, 16'h1369, 16'h148C, 16'h15AF, 16'h16D2, 16'h17F5};
    int got = 0;
    int last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_chk++;
        if (got >= 8 || sum !== ex[got < 8 ? got : 0]) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got %h expected %h", got, sum, ex[got < 8 ? got : 0]);
        end
        if (got > 0) begin
          n_chk++;
          if (c != last + 1) begin
            n_fail++;
            $display("FAIL b2b_gap%0d: got cycle %0d expected %0d", got, c, last + 1);
          end
        end
        last = c;
        got++;
      end
      if (c < 8) begin
        n_chk++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready%0d: got %b expected 1", c, in_ready);
        end
        a = ta[c]; b = 16'h1000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    n_chk++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 8", got);
    end
  endtask
  task automatic test_stall();
    int acc = 0;
    int got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_chk++;
        if ({sum, cout, ovf, zero} !== {16'h1010, 3'b000}) begin
          n_fail++;
          $display("FAIL stall_hold%0d: got %h expected %h", c, {sum, cout, ovf, zero}, {16'h1010, 3'b000});
        end
      end
      a = 16'h0010 + 16'(acc); b = 16'h1000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      if (in_ready) acc++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL stall_accepted: got %0d expected 4", acc);
    end
    n_chk++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_handshake {in_ready,out_valid}: got %b expected 01", {in_ready, out_valid});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        n_chk++;
        if (got >= 4 || sum !== 16'h1010 + 16'(got)) begin
          n_fail++;
          $display("FAIL stall_drain%0d: got %h expected %h", got, sum, 16'h1010 + 16'(got));
        end
        got++;
      end
      @(negedge clk);
    end
    n_chk++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL stall_drain_count: got %0d expected 4", got);
    end
  endtask
  task automatic test_flush(input bit use_rst);
    logic [18:0] res;
    int lat;
    int seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a = 16'h0001 + 16'(c); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL clear%0d_handshake {out_valid,in_ready}: got %b expected 01", use_rst, {out_valid, in_ready});
    end
    if (use_rst) begin
      n_chk++;
      if ({sum, cout, ovf, zero} !== 19'h0) begin
        n_fail++;
        $display("FAIL rst_data: got %h expected 00000", {sum, cout, ovf, zero});
      end
    end
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL clear%0d_stale: got %0d results expected 0", use_rst, seen);
    end
    run_one(16'h1234, 16'h4321, 1'b0, 1'b0, res, lat);
    n_chk++;
    if (res !== {16'h5555, 3'b000} || lat != 4) begin
      n_fail++;
      $display("FAIL clear%0d_after: got %h lat %0d expected %h lat 4", use_rst, res, lat, {16'h5555, 3'b000});
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
